// File: rtl/strand_loader.sv
// Serial strand front-end: packs incoming bits into DATA_WIDTH-bit words, buffers
// completed strands in a small FIFO and presents them with load_prep/load_on framing.
module strand_loader #(
    parameter int DATA_WIDTH  = 32,
    parameter int STACK_DEPTH = 16,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  bit_in,
    input  logic                  bit_valid,
    input  logic                  strand_end,
    input  logic                  cluster_end,
    output logic                  in_ready,
    input  logic                  out_stall,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic [31:0]           N_out,
    output logic                  load_prep,
    output logic                  load_on,
    output logic                  overflow,
    output logic                  dropped,
    output logic                  cluster_done
);

    localparam int LW = $clog2(DATA_WIDTH + 1);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(STACK_DEPTH + 1);

    localparam logic [LW-1:0] LEN_MAX  = LW'(DATA_WIDTH);
    localparam logic [CW-1:0] CNT_MAX  = CW'(STACK_DEPTH);
    localparam logic [AW:0]   FIFO_CAP = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic {
        S_IDLE    = 1'b0,
        S_COLLECT = 1'b1
    } state_t;

    state_t                state_q;
    logic [DATA_WIDTH-1:0] asm_q;
    logic [LW-1:0]         len_q;
    logic [CW-1:0]         cnt_q;
    logic                  overflow_q;
    logic                  dropped_q;

    logic [DATA_WIDTH-1:0] mem_data_q [FIFO_DEPTH];
    logic [LW-1:0]         mem_len_q  [FIFO_DEPTH];
    logic                  mem_last_q [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr_q;
    logic [AW-1:0]         rd_ptr_q;
    logic [AW:0]           count_q;

    logic [DATA_WIDTH-1:0] data_out_q;
    logic [31:0]           n_out_q;
    logic                  load_prep_q;
    logic                  load_on_q;
    logic                  cluster_done_q;

    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  acc;
    logic                  fits;
    logic                  strand_done;
    logic                  drop;
    logic                  pop;
    logic                  tail_live;
    logic                  wr_strand;
    logic                  wr_marker;
    logic                  fix_last;
    logic                  wr_en;
    logic [DATA_WIDTH-1:0] asm_d;
    logic [LW-1:0]         len_d;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [LW-1:0]         wr_len;
    logic                  wr_last;
    logic [AW-1:0]         tail_idx;
    logic [AW:0]           count_d;

    always_comb begin
        fifo_full   = (count_q == FIFO_CAP);
        fifo_empty  = (count_q == '0);
        in_ready    = !fifo_full;
        acc         = bit_valid && in_ready;
        fits        = (len_q != LEN_MAX);

        // Bits past DATA_WIDTH are discarded and the length saturates.
        asm_d       = asm_q;
        len_d       = len_q;
        if (fits) begin
            asm_d = asm_q | ({{(DATA_WIDTH-1){1'b0}}, bit_in} << len_q);
            len_d = len_q + LW'(1);
        end

        strand_done = acc && strand_end;
        drop        = strand_done && (cnt_q == CNT_MAX);
        pop         = !fifo_empty && !out_stall;

        // The newest entry is still buffered unless it is the one leaving this edge.
        tail_live   = (count_q - (AW + 1)'(pop)) != '0;
        tail_idx    = wr_ptr_q - AW'(1);

        wr_strand   = strand_done && !drop;
        wr_marker   = drop && cluster_end && !tail_live;
        fix_last    = drop && cluster_end && tail_live;
        wr_en       = wr_strand || wr_marker;

        wr_data     = wr_marker ? '0 : asm_d;
        wr_len      = wr_marker ? '0 : len_d;
        wr_last     = wr_marker ? 1'b1 : cluster_end;

        count_d     = count_q + (AW + 1)'(wr_en) - (AW + 1)'(pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            asm_q          <= '0;
            len_q          <= '0;
            cnt_q          <= '0;
            overflow_q     <= 1'b0;
            dropped_q      <= 1'b0;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            data_out_q     <= '0;
            n_out_q        <= '0;
            load_prep_q    <= 1'b0;
            load_on_q      <= 1'b0;
            cluster_done_q <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_data_q[i] <= '0;
                mem_len_q[i]  <= '0;
                mem_last_q[i] <= 1'b0;
            end
        end else begin
            if (acc) begin
                if (!fits) begin
                    overflow_q <= 1'b1;
                end
                if (strand_end) begin
                    state_q <= S_IDLE;
                    asm_q   <= '0;
                    len_q   <= '0;
                end else begin
                    state_q <= S_COLLECT;
                    asm_q   <= asm_d;
                    len_q   <= len_d;
                end
            end

            if (strand_done) begin
                if (cluster_end) begin
                    cnt_q <= '0;
                end else if (!drop) begin
                    cnt_q <= cnt_q + CW'(1);
                end
                if (drop) begin
                    dropped_q <= 1'b1;
                end
            end

            if (wr_en) begin
                mem_data_q[wr_ptr_q] <= wr_data;
                mem_len_q[wr_ptr_q]  <= wr_len;
                mem_last_q[wr_ptr_q] <= wr_last;
                wr_ptr_q             <= wr_ptr_q + AW'(1);
            end
            if (fix_last) begin
                mem_last_q[tail_idx] <= 1'b1;
            end

            // Output word/length hold their value between strobes.
            if (pop) begin
                data_out_q  <= mem_data_q[rd_ptr_q];
                n_out_q     <= 32'(mem_len_q[rd_ptr_q]);
                load_prep_q <= 1'b1;
                load_on_q   <= !mem_last_q[rd_ptr_q];
                rd_ptr_q    <= rd_ptr_q + AW'(1);
            end else begin
                load_prep_q <= 1'b0;
                load_on_q   <= 1'b0;
            end
            cluster_done_q <= load_prep_q && !load_on_q;
            count_q        <= count_d;
        end
    end

    assign data_out     = data_out_q;
    assign N_out        = n_out_q;
    assign load_prep    = load_prep_q;
    assign load_on      = load_on_q;
    assign overflow     = overflow_q;
    assign dropped      = dropped_q;
    assign cluster_done = cluster_done_q;

endmodule

// File: tb/tb_strand_loader.sv
// Directed bench for strand_loader: serial strands in, captured strobes checked
// against hand-computed expected words, lengths and framing flags.
module tb_strand_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        bit_in = 1'b0;
  logic        bit_valid = 1'b0;
  logic        strand_end = 1'b0;
  logic        cluster_end = 1'b0;
  logic        out_stall = 1'b0;
  logic        in_ready;
  logic [31:0] data_out;
  logic [31:0] N_out;
  logic        load_prep;
  logic        load_on;
  logic        overflow;
  logic        dropped;
  logic        cluster_done;

  int n_tests = 0;
  int n_fail = 0;
  int cd_cnt = 0;

  logic [31:0] cap_data_q[$];
  logic [31:0] cap_n_q[$];
  logic        cap_on_q[$];
  logic [31:0] exp_data_q[$];
  logic [31:0] exp_n_q[$];
  logic        exp_on_q[$];

  // clock / reset
  always #5 clk = ~clk;

  strand_loader #(
    .DATA_WIDTH(32),
    .STACK_DEPTH(16),
    .FIFO_DEPTH(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bit_in(bit_in),
    .bit_valid(bit_valid),
    .strand_end(strand_end),
    .cluster_end(cluster_end),
    .in_ready(in_ready),
    .out_stall(out_stall),
    .data_out(data_out),
    .N_out(N_out),
    .load_prep(load_prep),
    .load_on(load_on),
    .overflow(overflow),
    .dropped(dropped),
    .cluster_done(cluster_done)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // driver tasks: called at a negedge, return at a negedge
  task automatic send_bit(input logic b, input logic se, input logic ce);
    int t;
    t = 0;
    bit_in = b;
    strand_end = se;
    cluster_end = ce;
    bit_valid = 1'b1;
    while (!in_ready) begin
      if (t >= 1000) begin
        check("in_ready_wait", in_ready, 1);
        break;
      end
      @(negedge clk);
      t++;
    end
    @(negedge clk);
    bit_valid = 1'b0;
    strand_end = 1'b0;
    cluster_end = 1'b0;
  endtask

  task automatic send_strand(input logic [63:0] pat, input int n, input logic ce);
    for (int i = 0; i < n; i++) begin
      send_bit(pat[i], i == n - 1, ce && (i == n - 1));
    end
  endtask

  task automatic push_exp(input logic [31:0] d, input logic [31:0] n, input logic on);
    exp_data_q.push_back(d);
    exp_n_q.push_back(n);
    exp_on_q.push_back(on);
  endtask

  task automatic wait_strobes(input int n);
    int t;
    t = 0;
    while (cap_n_q.size() < n && t < 300) begin
      @(negedge clk);
      t++;
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic clear_caps();
    cap_data_q.delete();
    cap_n_q.delete();
    cap_on_q.delete();
    cd_cnt = 0;
  endtask

  // scoreboard: compare captured strobes against the expected queue, in order
  task automatic compare_strobes(input string tag);
    int k;
    check({tag, "_count"}, cap_n_q.size(), exp_n_q.size());
    k = 0;
    while (exp_n_q.size() > 0 && cap_n_q.size() > 0) begin
      check($sformatf("%s_data%0d", tag, k), cap_data_q.pop_front(), exp_data_q.pop_front());
      check($sformatf("%s_n%0d", tag, k), cap_n_q.pop_front(), exp_n_q.pop_front());
      check($sformatf("%s_on%0d", tag, k), cap_on_q.pop_front(), exp_on_q.pop_front());
      k++;
    end
    exp_data_q.delete();
    exp_n_q.delete();
    exp_on_q.delete();
    clear_caps();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    fork
      forever begin
        @(negedge clk);
        if (load_prep) begin
          cap_data_q.push_back(data_out);
          cap_n_q.push_back(N_out);
          cap_on_q.push_back(load_on);
        end
        if (cluster_done) cd_cnt++;
      end
    join_none

    // reset state
    repeat (2) @(negedge clk);
    check("rst_load_prep", load_prep, 0);
    check("rst_load_on", load_on, 0);
    check("rst_data_out", data_out, 0);
    check("rst_n_out", N_out, 0);
    check("rst_overflow", overflow, 0);
    check("rst_dropped", dropped, 0);
    check("rst_cluster_done", cluster_done, 0);
    check("rst_in_ready", in_ready, 1);
    rst_n = 1'b1;
    @(negedge clk);

    // single 5-bit strand 1,0,1,1,0: strobe 2 cycles after the last bit
    send_strand(64'h0D, 5, 1'b1);
    check("t1_prep_early", load_prep, 0);
    @(negedge clk);
    check("t1_prep", load_prep, 1);
    check("t1_data", data_out, 32'h0D);
    check("t1_n", N_out, 5);
    check("t1_on", load_on, 0);
    check("t1_cd_early", cluster_done, 0);
    @(negedge clk);
    check("t1_cd", cluster_done, 1);
    check("t1_prep_off", load_prep, 0);
    check("t1_data_hold", data_out, 32'h0D);
    check("t1_n_hold", N_out, 5);
    @(negedge clk);
    clear_caps();

    // cluster of three strands
    push_exp(32'hA5, 8, 1'b1);
    push_exp(32'h2C3, 10, 1'b1);
    push_exp(32'h5A, 7, 1'b0);
    send_strand(64'hA5, 8, 1'b0);
    send_strand(64'h2C3, 10, 1'b0);
    send_strand(64'h5A, 7, 1'b1);
    wait_strobes(3);
    check("t2_cluster_done", cd_cnt, 1);
    compare_strobes("t2");

    // 40-bit strand truncates to the first 32 bits
    push_exp(32'h1234_5678, 32, 1'b0);
    send_strand(64'hAB_1234_5678, 40, 1'b1);
    wait_strobes(1);
    check("t3_overflow", overflow, 1);
    check("t3_dropped", dropped, 0);
    compare_strobes("t3");

    // 18 one-bit strands, last two dropped while strand 16 is still buffered
    for (int i = 0; i < 14; i++) send_strand(64'h1, 1, 1'b0);
    repeat (3) @(negedge clk);
    out_stall = 1'b1;
    send_strand(64'h1, 1, 1'b0);
    send_strand(64'h1, 1, 1'b0);
    check("t4_dropped_before", dropped, 0);
    send_strand(64'h1, 1, 1'b0);
    send_strand(64'h1, 1, 1'b1);
    check("t4_dropped", dropped, 1);
    out_stall = 1'b0;
    for (int i = 0; i < 15; i++) push_exp(32'h1, 1, 1'b1);
    push_exp(32'h1, 1, 1'b0);
    wait_strobes(16);
    check("t4_cluster_done", cd_cnt, 1);
    compare_strobes("t4");

    // dropped cluster-ending strand after strand 16 already left: zero-length marker
    for (int i = 0; i < 16; i++) send_strand(64'h1, 1, 1'b0);
    send_strand(64'h1, 1, 1'b1);
    for (int i = 0; i < 16; i++) push_exp(32'h1, 1, 1'b1);
    push_exp(32'h0, 0, 1'b0);
    wait_strobes(17);
    check("t4m_cluster_done", cd_cnt, 1);
    compare_strobes("t4m");
    check("t4m_overflow_sticky", overflow, 1);

    // backpressure: five strands against a four-entry buffer
    out_stall = 1'b1;
    send_strand(64'h5, 3, 1'b0);
    send_strand(64'h9, 4, 1'b0);
    send_strand(64'h16, 5, 1'b0);
    check("t5_ready_3", in_ready, 1);
    send_strand(64'h2B, 6, 1'b0);
    check("t5_ready_4", in_ready, 0);
    push_exp(32'h5, 3, 1'b1);
    push_exp(32'h9, 4, 1'b1);
    push_exp(32'h16, 5, 1'b1);
    push_exp(32'h2B, 6, 1'b1);
    push_exp(32'h3, 2, 1'b0);
    fork
      send_strand(64'h3, 2, 1'b1);
      begin
        repeat (6) @(negedge clk);
        check("t5_ready_held", in_ready, 0);
        check("t5_no_strobe", cap_n_q.size(), 0);
        out_stall = 1'b0;
      end
    join
    wait_strobes(5);
    check("t5_cluster_done", cd_cnt, 1);
    compare_strobes("t5");

    // reset mid-strand with two entries buffered
    out_stall = 1'b1;
    send_strand(64'h6, 3, 1'b0);
    send_strand(64'h9, 4, 1'b0);
    send_bit(1'b1, 1'b0, 1'b0);
    send_bit(1'b0, 1'b0, 1'b0);
    send_bit(1'b1, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_data_zero", data_out, 0);
    check("t6_n_zero", N_out, 0);
    check("t6_overflow_clr", overflow, 0);
    check("t6_dropped_clr", dropped, 0);
    check("t6_prep_zero", load_prep, 0);
    check("t6_ready", in_ready, 1);
    @(negedge clk);
    out_stall = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    clear_caps();
    repeat (10) @(negedge clk);
    check("t6_quiet", cap_n_q.size(), 0);
    push_exp(32'h2D, 6, 1'b0);
    send_strand(64'h2D, 6, 1'b1);
    wait_strobes(1);
    check("t6_cluster_done", cd_cnt, 1);
    compare_strobes("t6");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/strand_loader.md
Name: strand_loader

Overview:
- Upstream front-end of the strand decoder.
- Receives read strands from the sequencing interface as a serial bit stream, one bit per cycle.
- Packs each strand into a DATA_WIDTH-bit word with its length.
- Buffers completed strands in a small FIFO and presents them to the decoder, one per handshake, with the load_prep/load_on cluster signalling the decoder expects: push qualifier, and "more strands follow" vs "last strand of cluster".

Parameters:
- DATA_WIDTH, 32: maximum strand length in bits; width of the packed word.
- STACK_DEPTH, 16: maximum strands per cluster accepted downstream; extra strands are dropped.
- FIFO_DEPTH, 4: completed-strand buffer entries, power of 2, at least 2.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- bit_in  input  1  serial strand bit.
- bit_valid  input  1  bit_in is valid this cycle.
- strand_end  input  1  qualified by bit_valid; this bit is the last bit of the strand.
- cluster_end  input  1  qualified by bit_valid & strand_end; this strand is the last of its cluster.
- in_ready  output  1  loader can accept a bit this cycle.
- out_stall  input  1  downstream cannot take a strand this cycle.
- data_out  output  DATA_WIDTH  packed strand; bit k is the k-th received bit; unused MSBs are 0.
- N_out  output  32 (int)  strand length in bits, 1..DATA_WIDTH.
- load_prep  output  1  one-cycle strand-valid strobe (push qualifier).
- load_on  output  1  with load_prep: 1 = more strands follow, 0 = last strand of cluster.
- overflow  output  1  sticky: some strand exceeded DATA_WIDTH bits.
- dropped  output  1  sticky: some strand was dropped for exceeding STACK_DEPTH.
- cluster_done  output  1  one-cycle pulse in the cycle after the last strand of a cluster is emitted.

Behaviour:
- Reset (async, rst_n=0). All outputs 0, FIFO empty, assembly register/length/strand count 0, sticky flags cleared. Reset mid-strand or mid-cluster discards all partial and buffered data. Nothing is emitted after reset until new bits arrive.
- Accepted bit. An accepted bit is bit_valid & in_ready. in_ready = !fifo_full. It is combinational from registered state only.
- Packing. An accepted bit is written at index len, then len increments.
  - If len == DATA_WIDTH, the bit is discarded, len saturates and overflow sets.
  - On an accepted bit with strand_end, the completed word and length (including the current bit) are written to the FIFO in the same edge. The last flag is cluster_end.
  - The assembly register and len clear on the same edge, so the next cycle may start a new strand.
- Strand count. This counts strands written in the current cluster.
  - A strand whose count would exceed STACK_DEPTH is not written, and dropped sets.
  - If that dropped strand carries cluster_end, the most recently written FIFO entry's last flag is set instead.
  - If the FIFO entry holding that strand has already been emitted, the loader writes a zero-length marker entry. This entry is emitted as load_prep=1, load_on=0, N_out=0.
  - The count resets after any strand with cluster_end.
- States: IDLE (len=0, no partial strand) and COLLECT (partial strand held).
  - IDLE -> COLLECT on an accepted bit without strand_end.
  - COLLECT -> IDLE on an accepted bit with strand_end.
  - An accepted bit with strand_end in IDLE is a 1-bit strand and stays in IDLE.
- Emit.
  - When the FIFO is non-empty and out_stall=0, the head entry pops.
  - In the next cycle, data_out/N_out hold the entry, load_prep=1 and load_on=!last.
  - Latency is 1 cycle from pop to strobe and 2 cycles minimum from the strand_end bit to load_prep. At most one strand is emitted per cycle.
  - data_out/N_out hold their value while load_prep=0.
  - load_on=0 for exactly one strobe per cluster.
- Simultaneous write and pop on the same edge are both performed, so the FIFO count is unchanged.
- When the FIFO is full and out_stall=1, in_ready=0 and no bits are lost.
- cluster_done pulses in the cycle after the strobe with load_on=0.

Test Plan:
- Reset, then 5-bit strand 1,0,1,1,0 with strand_end+cluster_end on the 5th bit -> 2 cycles later load_prep=1, data_out=0x0D, N_out=5, load_on=0; cluster_done 1 cycle later.
- Cluster of 3 strands (lengths 8, 10, 7), out_stall=0 -> three strobes with N_out 8, 10, 7 and load_on 1, 1, 0.
- 40-bit strand with DATA_WIDTH=32 -> N_out=32, data_out = first 32 bits, overflow=1 and stays 1 until reset.
- 18 one-bit strands in one cluster with STACK_DEPTH=16 -> exactly 16 strobes, the 16th with load_on=0, dropped=1.
- out_stall=1 while 5 strands complete (FIFO_DEPTH=4) -> in_ready falls after the 4th strand completes. Release stall -> all 5 strands emitted in order, no bit lost.
- rst_n pulsed low mid-strand with 2 entries buffered -> outputs immediately 0; the next strand after reset is emitted alone with correct N_out.
